// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: issues loads/stores on a req/addr_ok/data_ok data-SRAM bus and hands results to WB.
// Optional macro MEM_DATA_OK_FASTPATH_EN lets a data_ok cycle complete the instruction without a DONE cycle.
module mem_stage_sram #(
   parameter int EX_TO_MEM_BUS_WD = 113,
   parameter int MEM_TO_WB_BUS_WD = 111,
   parameter int MEM_TO_BY_BUS_WD = 39
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        EX_to_MEM_valid,
   input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
   output logic                        MEM_allow_in,
   output logic                        MEM_to_WB_valid,
   output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
   input  logic                        WB_allow_in,
   output logic [MEM_TO_BY_BUS_WD-1:0] MEM_to_BY_bus,
   output logic                        data_sram_req,
   output logic                        data_sram_wr,
   output logic [3:0]                  data_sram_wstrb,
   output logic [31:0]                 data_sram_addr,
   output logic [31:0]                 data_sram_wdata,
   input  logic                        data_sram_addr_ok,
   input  logic                        data_sram_data_ok,
   input  logic [31:0]                 data_sram_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic                        mem_valid;
   logic [EX_TO_MEM_BUS_WD-1:0] mem_reg;
   logic [31:0]                 rdata_reg;
   logic [1:0]                  state;
   logic [1:0]                  state_next;

   logic [2:0]  stage;
   logic        sel_rf_w_en;
   logic        sel_rf_w_data;
   logic        sel_data_ram_wd;
   logic [3:0]  data_ram_b_en;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] store_data;
   logic [4:0]  rf_w_addr;
   logic [31:0] alu_result;
   logic [31:0] inst_pc;

   logic        is_mem_op;
   logic        in_is_mem_op;
   logic        data_done;
   logic        ready_go;
   logic        accept;
   logic        leaving;
   logic [31:0] rdata_now;
   logic [31:0] wb_rdata;
   logic [31:0] fwd_data;
   logic        fwd_valid;

   assign stage           = mem_reg[112:110];
   assign sel_rf_w_en     = mem_reg[109];
   assign sel_rf_w_data   = mem_reg[108];
   assign sel_data_ram_wd = mem_reg[107];
   assign data_ram_b_en   = mem_reg[106:103];
   assign mem_re          = mem_reg[102];
   assign mem_we          = mem_reg[101];
   assign store_data      = mem_reg[100:69];
   assign rf_w_addr       = mem_reg[68:64];
   assign alu_result      = mem_reg[63:32];
   assign inst_pc         = mem_reg[31:0];

   assign is_mem_op    = mem_re | mem_we;
   assign in_is_mem_op = EX_to_MEM_bus[102] | EX_to_MEM_bus[101];

   // data_ok only counts once the request has been accepted; stray responses are ignored.
   assign data_done = ((state == WAIT) & data_sram_data_ok) |
                      ((state == REQ) & data_sram_addr_ok & data_sram_data_ok);

`ifdef MEM_DATA_OK_FASTPATH_EN
   assign ready_go  = ~is_mem_op | (state == DONE) | data_done;
   assign rdata_now = data_done ? data_sram_rdata : rdata_reg;
`else
   assign ready_go  = ~is_mem_op | (state == DONE);
   assign rdata_now = rdata_reg;
`endif

   assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
   assign MEM_to_WB_valid = mem_valid & ready_go;
   assign accept          = EX_to_MEM_valid & MEM_allow_in;
   assign leaving         = mem_valid & ready_go & WB_allow_in;

   // A newly accepted instruction always restarts the FSM, even straight out of DONE.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = in_is_mem_op ? REQ : IDLE;
      end else if (leaving) begin
         state_next = IDLE;
      end else begin
         case (state)
            REQ: begin
               if (data_sram_addr_ok) begin
                  state_next = data_sram_data_ok ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (data_sram_data_ok) begin
                  state_next = DONE;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         mem_reg   <= '0;
         rdata_reg <= '0;
         state     <= IDLE;
      end else begin
         if (MEM_allow_in) begin
            mem_valid <= EX_to_MEM_valid;
         end
         if (accept) begin
            mem_reg <= EX_to_MEM_bus;
         end
         if (data_done & mem_re) begin
            rdata_reg <= data_sram_rdata;
         end
         state <= state_next;
      end
   end

   // Request fields come straight from mem_reg, which cannot change while a request is pending.
   assign data_sram_req   = (state == REQ);
   assign data_sram_wr    = mem_we;
   assign data_sram_wstrb = mem_we ? data_ram_b_en : 4'b0000;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = store_data;

   assign wb_rdata = mem_re ? rdata_now : 32'h0;

   assign MEM_to_WB_bus = {stage, sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd, data_ram_b_en,
                           wb_rdata, rf_w_addr, alu_result, inst_pc};

   assign fwd_valid = mem_valid & ready_go & (stage[0] | stage[1]);
   assign fwd_data  = sel_rf_w_data ? rdata_now : alu_result;

   assign MEM_to_BY_bus = {rf_w_addr, fwd_data, fwd_valid, sel_rf_w_en};

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed testbench for mem_stage_sram: non-memory ops, loads, stores, WB stalls, reset mid-transaction, bypass.
// Expected values follow the MEM_DATA_OK_FASTPATH_EN setting used for the build.
module tb_mem_stage_sram;

   logic         clk;
   logic         reset;
   logic         ex_valid;
   logic [112:0] ex_bus;
   logic         mem_allow_in;
   logic         to_wb_valid;
   logic [110:0] to_wb_bus;
   logic         wb_allow_in;
   logic [38:0]  to_by_bus;
   logic         sram_req;
   logic         sram_wr;
   logic [3:0]   sram_wstrb;
   logic [31:0]  sram_addr;
   logic [31:0]  sram_wdata;
   logic         sram_addr_ok;
   logic         sram_data_ok;
   logic [31:0]  sram_rdata;

   int assert_count = 0;
   int fail_count   = 0;

   mem_stage_sram dut (
      .clk               (clk),
      .reset             (reset),
      .EX_to_MEM_valid   (ex_valid),
      .EX_to_MEM_bus     (ex_bus),
      .MEM_allow_in      (mem_allow_in),
      .MEM_to_WB_valid   (to_wb_valid),
      .MEM_to_WB_bus     (to_wb_bus),
      .WB_allow_in       (wb_allow_in),
      .MEM_to_BY_bus     (to_by_bus),
      .data_sram_req     (sram_req),
      .data_sram_wr      (sram_wr),
      .data_sram_wstrb   (sram_wstrb),
      .data_sram_addr    (sram_addr),
      .data_sram_wdata   (sram_wdata),
      .data_sram_addr_ok (sram_addr_ok),
      .data_sram_data_ok (sram_data_ok),
      .data_sram_rdata   (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [112:0] mk_ex(input logic [2:0] stg, input logic wen, input logic wdsel,
                                          input logic ramwd, input logic [3:0] ben, input logic re,
                                          input logic we, input logic [31:0] sdata, input logic [4:0] rd,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {stg, wen, wdsel, ramwd, ben, re, we, sdata, rd, alu, pc};
   endfunction

   // WB payload: control fields and addr/alu/pc pass through, store data is replaced by read data.
   function automatic logic [110:0] mk_wb(input logic [112:0] ex, input logic [31:0] rdata);
      return {ex[112:110], ex[109], ex[108], ex[107], ex[106:103], rdata, ex[68:0]};
   endfunction

   function automatic logic [38:0] mk_by(input logic [4:0] rd, input logic [31:0] data,
                                         input logic fv, input logic wen);
      return {rd, data, fv, wen};
   endfunction

   // Drives one cycle of inputs just after the clock edge and lets the combinational outputs settle.
   task automatic applyStimulus(input logic rst, input logic v, input logic [112:0] bus,
                                input logic wb, input logic aok, input logic dok,
                                input logic [31:0] rdata);
      @(posedge clk);
      #1;
      reset        = rst;
      ex_valid     = v;
      ex_bus       = bus;
      wb_allow_in  = wb;
      sram_addr_ok = aok;
      sram_data_ok = dok;
      sram_rdata   = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      assert_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   logic [112:0] nm_op, ld_op, st_op, ld2_op, ld3_op, ld4_op;

   initial begin
      nm_op  = mk_ex(3'b001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd3, 32'h1234, 32'h100);
      ld_op  = mk_ex(3'b010, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 32'h0, 5'd5, 32'h1C, 32'h104);
      st_op  = mk_ex(3'b000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 32'hAABBCCDD, 5'd0, 32'h2002, 32'h108);
      ld2_op = mk_ex(3'b010, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 32'h0, 5'd7, 32'h40, 32'h10C);
      ld3_op = mk_ex(3'b010, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 32'h0, 5'd9, 32'h80, 32'h110);
      ld4_op = mk_ex(3'b010, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 32'h0, 5'd5, 32'h1C0, 32'h114);

      reset = 1'b1; ex_valid = 1'b0; ex_bus = '0; wb_allow_in = 1'b1;
      sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;

      // Reset state
      applyStimulus(1, 0, '0, 1, 0, 0, 0);
      applyStimulus(1, 0, '0, 1, 0, 0, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("reset_req", sram_req, 0);
      checkOutput("reset_wb_valid", to_wb_valid, 0);
      checkOutput("reset_allow_in", mem_allow_in, 1);
      checkOutput("reset_fwd_valid", to_by_bus[1], 0);

      // Non-memory op completes the cycle after acceptance
      applyStimulus(0, 1, nm_op, 1, 0, 0, 0);
      checkOutput("nm_allow_in", mem_allow_in, 1);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("nm_wb_valid", to_wb_valid, 1);
      checkOutput("nm_req", sram_req, 0);
      checkOutput("nm_wb_bus", to_wb_bus, mk_wb(nm_op, 32'h0));
      checkOutput("nm_by_bus", to_by_bus, mk_by(5'd3, 32'h1234, 1'b1, 1'b1));
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("nm_gone", to_wb_valid, 0);

      // Load: addr_ok at cycle 2, data_ok at cycle 4
      applyStimulus(0, 1, ld_op, 1, 0, 0, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("ld_c1_req", {sram_req, sram_wr, sram_wstrb, sram_addr}, {1'b1, 1'b0, 4'b0000, 32'h1C});
      checkOutput("ld_c1_allow_in", mem_allow_in, 0);
      applyStimulus(0, 0, '0, 1, 1, 0, 0);
      checkOutput("ld_c2_req", sram_req, 1);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("ld_c3_req", sram_req, 0);
      checkOutput("ld_c3_wb_valid", to_wb_valid, 0);
      applyStimulus(0, 0, '0, 1, 0, 1, 32'hDEADBEEF);
`ifdef MEM_DATA_OK_FASTPATH_EN
      checkOutput("ld_c4_wb_valid", to_wb_valid, 1);
      checkOutput("ld_c4_wb_bus", to_wb_bus, mk_wb(ld_op, 32'hDEADBEEF));
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("ld_c5_wb_valid", to_wb_valid, 0);
`else
      checkOutput("ld_c4_wb_valid", to_wb_valid, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("ld_c5_wb_valid", to_wb_valid, 1);
      checkOutput("ld_c5_wb_bus", to_wb_bus, mk_wb(ld_op, 32'hDEADBEEF));
`endif
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("ld_c6_wb_valid", to_wb_valid, 0);

      // Store with addr_ok held low for 3 cycles
      applyStimulus(0, 1, st_op, 0, 0, 0, 0);
      checkOutput("st_allow_in", mem_allow_in, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, '0, 0, 0, 0, 0);
         checkOutput($sformatf("st_req_stable_%0d", i),
                     {sram_req, sram_wr, sram_wstrb, sram_addr, sram_wdata},
                     {1'b1, 1'b1, 4'b0100, 32'h2002, 32'hAABBCCDD});
      end
      applyStimulus(0, 0, '0, 0, 1, 0, 0);
      checkOutput("st_req_addr_ok", sram_req, 1);
      applyStimulus(0, 0, '0, 0, 0, 1, 32'h55555555);
      checkOutput("st_wait_req", sram_req, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("st_wb_valid", to_wb_valid, 1);
      checkOutput("st_wb_bus", to_wb_bus, mk_wb(st_op, 32'h0));
      checkOutput("st_fwd_valid", to_by_bus[1], 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("st_gone", to_wb_valid, 0);

      // Load stalled in DONE by WB for 2 cycles, then hand-off to a waiting load
      applyStimulus(0, 1, ld2_op, 0, 0, 0, 0);
      applyStimulus(0, 0, '0, 0, 1, 1, 32'h12345678);
      checkOutput("stall_req", sram_req, 1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, ld3_op, 0, 0, 0, 0);
         checkOutput($sformatf("stall_wb_valid_%0d", i), to_wb_valid, 1);
         checkOutput($sformatf("stall_allow_in_%0d", i), mem_allow_in, 0);
         checkOutput($sformatf("stall_wb_bus_%0d", i), to_wb_bus, mk_wb(ld2_op, 32'h12345678));
      end
      applyStimulus(0, 1, ld3_op, 1, 0, 0, 0);
      checkOutput("handoff_allow_in", mem_allow_in, 1);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("handoff_req", {sram_req, sram_addr}, {1'b1, 32'h80});
      checkOutput("handoff_wb_valid", to_wb_valid, 0);

      // Reset while in WAIT; the late data_ok must be discarded
      applyStimulus(0, 0, '0, 1, 1, 0, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("rst_wait_req", sram_req, 0);
      reset = 1'b1;
      applyStimulus(0, 0, '0, 1, 0, 1, 32'hBAD0BAD0);
      checkOutput("rst_late_req", sram_req, 0);
      checkOutput("rst_late_wb_valid", to_wb_valid, 0);
      checkOutput("rst_late_allow_in", mem_allow_in, 1);
      checkOutput("rst_late_wb_bus", to_wb_bus, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("rst_after_wb_valid", to_wb_valid, 0);
      checkOutput("rst_after_req", sram_req, 0);

      // Bypass for a load with stage[1]=1, rd=5
      applyStimulus(0, 1, ld4_op, 0, 0, 0, 0);
      applyStimulus(0, 0, '0, 0, 1, 0, 0);
      checkOutput("by_req_fwd_valid", to_by_bus[1], 0);
      applyStimulus(0, 0, '0, 0, 0, 1, 32'hCAFEF00D);
`ifdef MEM_DATA_OK_FASTPATH_EN
      checkOutput("by_dok_fwd", to_by_bus, mk_by(5'd5, 32'hCAFEF00D, 1'b1, 1'b1));
`else
      checkOutput("by_dok_fwd_valid", to_by_bus[1], 0);
`endif
      applyStimulus(0, 0, '0, 0, 0, 0, 0);
      checkOutput("by_done_fwd", to_by_bus, mk_by(5'd5, 32'hCAFEF00D, 1'b1, 1'b1));
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("by_leave_fwd", to_by_bus, mk_by(5'd5, 32'hCAFEF00D, 1'b1, 1'b1));
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkOutput("by_after_fwd_valid", to_by_bus[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
